// File: rtl/usb1_pkg.sv
// -----------------------------------------------------------------------------
// usb1_pkg
// Shared constants and types for the USB 1.1 endpoint data path.
//   USB1_EP_DW : endpoint FIFO data width (one byte)
//   USB1_EP_AW : endpoint FIFO address width (depth = 2**USB1_EP_AW)
//   ep_level_t : FIFO occupancy, wide enough to hold 0..2**USB1_EP_AW
// -----------------------------------------------------------------------------
package usb1_pkg;

    localparam int USB1_EP_DW = 8;
    localparam int USB1_EP_AW = 6;

    typedef logic [USB1_EP_AW:0] ep_level_t;

endpackage : usb1_pkg

// File: rtl/usb1_ep_ram.sv
// -----------------------------------------------------------------------------
// usb1_ep_ram
// Simple dual-port storage for the endpoint FIFO: one write port and one
// registered read port, 2**AW x DW. Written so that it maps onto block RAM
// with an output register.
// Ports:
//   clk_i     in  1   clock, rising edge
//   we_i      in  1   write strobe
//   waddr_i   in  AW  write address
//   wdata_i   in  DW  write data
//   re_i      in  1   read strobe; loads the output register
//   raddr_i   in  AW  read address
//   rd_rst_i  in  1   synchronous clear of the output register only
//   rdata_o   out DW  registered read data
// -----------------------------------------------------------------------------
module usb1_ep_ram
    import usb1_pkg::*;
#(
    parameter int DW = USB1_EP_DW,
    parameter int AW = USB1_EP_AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          rd_rst_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage array is never reset; stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register: holds its value between reads, clearable so the
    // FIFO's read data comes out of reset/flush as zero.
    always_ff @(posedge clk_i) begin
        if (rd_rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : usb1_ep_ram

// File: rtl/usb1_ep_fifo.sv
// -----------------------------------------------------------------------------
// usb1_ep_fifo
// Byte-wide synchronous endpoint FIFO sitting between the USB core endpoint
// port and the application. Registered read (data appears the cycle after an
// accepted read), occupancy count, sticky overflow/underflow flags and a
// registered packet-ready flag used by the core's buffer-fill logic.
// Ports:
//   clk_i      in  1     clock, rising edge
//   rst_i      in  1     synchronous active-high reset
//   clr        in  1     synchronous flush (pointers, count, flags, dout)
//   din        in  DW    write data
//   we         in  1     write enable (accepted when not full)
//   full       out 1     level == 2**AW
//   dout       out DW    read data, valid the cycle after an accepted read
//   re         in  1     read enable (accepted when not empty)
//   empty      out 1     level == 0
//   level      out AW+1  occupancy 0..2**AW
//   bf_thresh  in  AW+1  packet-ready threshold in bytes, 0 disables
//   pkt_rdy    out 1     bf_thresh != 0 && level >= bf_thresh (registered)
//   ovf        out 1     sticky: write attempted while full
//   unf        out 1     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module usb1_ep_fifo
    import usb1_pkg::*;
#(
    parameter int DW = USB1_EP_DW,
    parameter int AW = USB1_EP_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    output logic          full,
    output logic [DW-1:0] dout,
    input  logic          re,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [AW:0]   bf_thresh,
    output logic          pkt_rdy,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;
    logic          pkt_rdy_q, pkt_rdy_d;

    logic          flush;
    logic          full_w;
    logic          empty_w;
    logic          wr_acc;
    logic          rd_acc;

    function automatic logic thresh_hit(input logic [AW:0] lvl,
                                        input logic [AW:0] th);
        return (th != '0) && (lvl >= th);
    endfunction

    // Status is decoded from the registered count only, so nothing on the
    // output side depends combinationally on we/re.
    assign full_w  = (level_q == DEPTH);
    assign empty_w = (level_q == '0);
    assign flush   = rst_i || clr;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        pkt_rdy_d = pkt_rdy_q;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            pkt_rdy_d = 1'b0;
        end else begin
            wr_acc = we && !full_w;
            rd_acc = re && !empty_w;

            if (we && full_w) begin
                ovf_d = 1'b1;
            end
            if (re && empty_w) begin
                unf_d = 1'b1;
            end

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            level_d   = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
            // Evaluated on the next count so the flag moves in the same cycle
            // as level.
            pkt_rdy_d = thresh_hit(level_d, bf_thresh);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            pkt_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            pkt_rdy_q <= pkt_rdy_d;
        end
    end

    // wr_acc/rd_acc are already forced low during reset/flush, so a flush
    // never commits the write presented in the same cycle.
    usb1_ep_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk_i    (clk_i),
        .we_i     (wr_acc),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (din),
        .re_i     (rd_acc),
        .raddr_i  (rd_ptr_q),
        .rd_rst_i (flush),
        .rdata_o  (dout)
    );

    assign full    = full_w;
    assign empty   = empty_w;
    assign level   = level_q;
    assign pkt_rdy = pkt_rdy_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule : usb1_ep_fifo

// File: tb/tb_usb1_ep_fifo.sv
// -----------------------------------------------------------------------------
// tb_usb1_ep_fifo
// Self-checking bench for usb1_ep_fifo. A queue-based reference model tracks
// contents, read data, sticky flags and packet-ready; directed scenarios and
// randomized traffic are compared against it.
// -----------------------------------------------------------------------------
module tb_usb1_ep_fifo;
    import usb1_pkg::*;

    localparam int DEPTH = 64;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clr;
    logic [7:0] din;
    logic       we;
    logic       full;
    logic [7:0] dout;
    logic       re;
    logic       empty;
    ep_level_t  level;
    ep_level_t  bf_thresh;
    logic       pkt_rdy;
    logic       ovf;
    logic       unf;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit         m_ovf, m_unf, m_pkt;

    always #5 clk_i = ~clk_i;

    usb1_ep_fifo dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr       (clr),
        .din       (din),
        .we        (we),
        .full      (full),
        .dout      (dout),
        .re        (re),
        .empty     (empty),
        .level     (level),
        .bf_thresh (bf_thresh),
        .pkt_rdy   (pkt_rdy),
        .ovf       (ovf),
        .unf       (unf)
    );

    // Apply the FIFO rules to the current inputs, as the clock edge will.
    task automatic model_edge();
        bit was_full, was_empty;
        if (rst_i || clr) begin
            mq.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_pkt  = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (we && was_full)  m_ovf = 1'b1;
            if (re && was_empty) m_unf = 1'b1;
            if (re && !was_empty) m_dout = mq.pop_front();
            if (we && !was_full)  mq.push_back(din);
            m_pkt = (bf_thresh != 0) && (mq.size() >= int'(bf_thresh));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_i = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic do_clr();
        idle(); clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        idle(); we = 1'b1; din = v; step(); we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 60; i++) begin
            idle();
            we  = ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 2) == 0);
            din = 8'($urandom());
            step();
            n_chk++;
            if (level !== ep_level_t'(mq.size()) || dout !== m_dout) begin
                n_fail++;
                $display("FAIL reset_traffic: level=%0d dout=%02h required level=%0d dout=%02h",
                         level, dout, mq.size(), m_dout);
            end
        end
        idle(); rst_i = 1'b1; step(); step(); rst_i = 1'b0;
        n_chk++;
        if ({empty, full, level, dout, ovf, unf, pkt_rdy} !== {1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: empty=%b full=%b level=%0d dout=%02h ovf=%b unf=%b pkt=%b required 1 0 0 00 0 0 0",
                     empty, full, level, dout, ovf, unf, pkt_rdy);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        n_chk++;
        if (full !== 1'b1 || level !== 7'd64 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full=%b level=%0d empty=%b required full=1 level=64 empty=0", full, level, empty);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); re = 1'b1; step();
            n_chk++;
            if (dout !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain_data[%0d]: dout=%02h required %02h", i, dout, 8'(i));
            end
        end
        idle();
        n_chk++;
        if (empty !== 1'b1 || level !== 7'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b level=%0d full=%b required empty=1 level=0 full=0", empty, level, full);
        end
    endtask

    task automatic test_ovf_unf();
        logic [7:0] last;
        for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 8'hA9)));
        push(8'hAA);
        n_chk++;
        if (ovf !== 1'b1 || level !== 7'd64 || unf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b level=%0d unf=%b required ovf=1 level=64 unf=0", ovf, level, unf);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(); re = 1'b1; step();
            n_chk++;
            if (dout !== m_dout || dout === 8'hAA) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: dout=%02h required %02h", i, dout, m_dout);
            end
        end
        last = m_dout;
        idle(); re = 1'b1; step(); idle();
        n_chk++;
        if (unf !== 1'b1 || dout !== last || level !== 7'd0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_set: unf=%b dout=%02h level=%0d ovf=%b required unf=1 dout=%02h level=0 ovf=1",
                     unf, dout, level, ovf, last);
        end
        do_clr();
        n_chk++;
        if (ovf !== 1'b0 || unf !== 1'b0 || level !== 7'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_flags: ovf=%b unf=%b level=%0d empty=%b required 0 0 0 1", ovf, unf, level, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 10; i++) push(8'($urandom()));
        for (int i = 0; i < 100; i++) begin
            idle(); we = 1'b1; re = 1'b1; din = 8'($urandom()); step();
            n_chk++;
            if (level !== 7'd10 || dout !== m_dout) begin
                n_fail++;
                $display("FAIL simul_mid[%0d]: level=%0d dout=%02h required level=10 dout=%02h", i, level, dout, m_dout);
            end
        end
        while (mq.size() < DEPTH) push(8'($urandom()));
        idle(); we = 1'b1; re = 1'b1; din = 8'h5A; step(); idle();
        n_chk++;
        if (level !== 7'd63 || ovf !== 1'b1 || dout !== m_dout) begin
            n_fail++;
            $display("FAIL simul_full: level=%0d ovf=%b dout=%02h required level=63 ovf=1 dout=%02h", level, ovf, dout, m_dout);
        end
        do_clr();
        idle(); we = 1'b1; re = 1'b1; din = 8'hC3; step(); idle();
        n_chk++;
        if (level !== 7'd1 || unf !== 1'b1 || dout !== 8'h00 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty: level=%0d unf=%b dout=%02h empty=%b required level=1 unf=1 dout=00 empty=0",
                     level, unf, dout, empty);
        end
        idle(); re = 1'b1; step(); idle();
        n_chk++;
        if (dout !== 8'hC3) begin
            n_fail++;
            $display("FAIL simul_empty_data: dout=%02h required c3", dout);
        end
    endtask

    task automatic test_threshold();
        do_clr();
        bf_thresh = 7'd8;
        for (int i = 0; i < 7; i++) begin
            push(8'($urandom()));
            n_chk++;
            if (pkt_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL thresh_below[%0d]: pkt_rdy=%b required 0", i + 1, pkt_rdy);
            end
        end
        push(8'($urandom()));
        n_chk++;
        if (pkt_rdy !== 1'b1 || level !== 7'd8) begin
            n_fail++;
            $display("FAIL thresh_hit: pkt_rdy=%b level=%0d required pkt_rdy=1 level=8", pkt_rdy, level);
        end
        idle(); re = 1'b1; step(); idle();
        n_chk++;
        if (pkt_rdy !== 1'b0 || level !== 7'd7) begin
            n_fail++;
            $display("FAIL thresh_drop: pkt_rdy=%b level=%0d required pkt_rdy=0 level=7", pkt_rdy, level);
        end
        bf_thresh = 7'd0;
        while (mq.size() < DEPTH) begin
            push(8'($urandom()));
            n_chk++;
            if (pkt_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL thresh_disabled: pkt_rdy=%b level=%0d required 0", pkt_rdy, level);
            end
        end
        bf_thresh = 7'd64;
        idle(); step();
        n_chk++;
        if (pkt_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_full: pkt_rdy=%b required 1", pkt_rdy);
        end
        do_clr();
        bf_thresh = 7'd0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 20; i++) push(8'($urandom()));
        idle(); clr = 1'b1; we = 1'b1; re = 1'b1; din = 8'hEE; step(); idle();
        n_chk++;
        if (level !== 7'd0 || empty !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL flush: level=%0d empty=%b dout=%02h required level=0 empty=1 dout=00", level, empty, dout);
        end
        step();
        n_chk++;
        if (level !== 7'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_hold: level=%0d empty=%b required level=0 empty=1", level, empty);
        end
        push(8'h3C);
        idle(); re = 1'b1; step(); idle();
        n_chk++;
        if (dout !== 8'h3C || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after: dout=%02h empty=%b required dout=3c empty=1", dout, empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            idle();
            if (i % 250 == 0) bf_thresh = ep_level_t'($urandom_range(0, 70));
            rst_i = ($urandom_range(0, 999) == 0);
            clr   = ($urandom_range(0, 199) == 0);
            if ((i / 300) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            din = 8'($urandom());
            step();
            n_chk++;
            if (level !== ep_level_t'(mq.size()) || dout !== m_dout ||
                full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                ovf !== m_ovf || unf !== m_unf || pkt_rdy !== m_pkt) begin
                n_fail++;
                $display("FAIL random[%0d]: lvl=%0d dout=%02h f=%b e=%b ovf=%b unf=%b pkt=%b required lvl=%0d dout=%02h ovf=%b unf=%b pkt=%b",
                         i, level, dout, full, empty, ovf, unf, pkt_rdy, mq.size(), m_dout, m_ovf, m_unf, m_pkt);
            end
        end
        idle();
    endtask

    initial begin
        rst_i = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00; bf_thresh = 7'd0;
        step(); step();
        rst_i = 1'b0;
        test_reset();
        test_fill_drain();
        test_ovf_unf();
        test_simultaneous();
        test_threshold();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_usb1_ep_fifo
